// File: rtl/bsg_manycore_block_mem_arb.sv
// Block-memory controller: post-reset zero-fill sweep, then round-robin sharing of one SRAM port between two requesters.
// Latency: grant is combinational, read data returns 1 cycle after grant; a 1-entry slot per port holds data until yumi.
module bsg_manycore_block_mem_arb #(
    parameter int data_width_p        = 32,
    parameter int mem_size_in_words_p = 1024,
    parameter int zero_init_p         = 1,
    localparam int mem_addr_width_lp  = (mem_size_in_words_p <= 1) ? 1 : $clog2(mem_size_in_words_p),
    localparam int mask_width_lp      = data_width_p / 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [1:0]                     req_v_i,
    input  logic [1:0]                     req_w_i,
    input  logic [2*mem_addr_width_lp-1:0] req_addr_i,
    input  logic [2*data_width_p-1:0]      req_data_i,
    input  logic [2*mask_width_lp-1:0]     req_mask_i,
    output logic [1:0]                     req_ready_o,
    output logic [1:0]                     resp_v_o,
    output logic [2*data_width_p-1:0]      resp_data_o,
    input  logic [1:0]                     resp_yumi_i,
    output logic                           init_done_o,
    output logic                           mem_v_o,
    output logic                           mem_w_o,
    output logic [mem_addr_width_lp-1:0]   mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [mask_width_lp-1:0]       mem_mask_o,
    input  logic [data_width_p-1:0]        mem_data_i
);

    localparam int AW = mem_addr_width_lp;
    localparam int DW = data_width_p;
    localparam int MW = mask_width_lp;

    typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [1:0]      r_inflight;
    logic [1:0]      r_held;
    logic            r_last;
    logic [DW-1:0]   r_hold [2];

    logic [1:0]      w_elig;
    logic [1:0]      w_cand;
    logic [1:0]      w_grant;
    logic            w_gsel;

    // A read may only be granted when its response slot is guaranteed free next cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = req_w_i[i] | ~(r_inflight[i] | r_held[i]) | resp_yumi_i[i];
        end
        w_cand     = (r_state == S_READY && !reset_i) ? (req_v_i & w_elig) : 2'b00;
        w_grant[0] = w_cand[0] & (~w_cand[1] | r_last);
        w_grant[1] = w_cand[1] & (~w_cand[0] | ~r_last);
        w_gsel     = w_grant[1];
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_cnt == AW'(mem_size_in_words_p - 1)) begin
            w_state_nxt = S_READY;
        end
    end

    always_comb begin
        req_ready_o = 2'b00;
        init_done_o = 1'b0;
        mem_v_o     = 1'b0;
        mem_w_o     = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        mem_mask_o  = '0;
        resp_v_o    = 2'b00;
        resp_data_o = '0;
        if (!reset_i) begin
            if (r_state == S_INIT) begin
                mem_v_o    = 1'b1;
                mem_w_o    = 1'b1;
                mem_addr_o = r_cnt;
                mem_mask_o = '1;
            end else begin
                init_done_o = 1'b1;
                req_ready_o = w_grant;
                if (|w_grant) begin
                    mem_v_o    = 1'b1;
                    mem_w_o    = w_gsel ? req_w_i[1] : req_w_i[0];
                    mem_addr_o = w_gsel ? req_addr_i[AW +: AW] : req_addr_i[0 +: AW];
                    mem_data_o = w_gsel ? req_data_i[DW +: DW] : req_data_i[0 +: DW];
                    mem_mask_o = w_gsel ? req_mask_i[MW +: MW] : req_mask_i[0 +: MW];
                end
            end
            resp_v_o = r_inflight | r_held;
            for (int i = 0; i < 2; i++) begin
                if (r_held[i]) begin
                    resp_data_o[i*DW +: DW] = r_hold[i];
                end else if (r_inflight[i]) begin
                    resp_data_o[i*DW +: DW] = mem_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= (zero_init_p != 0) ? S_INIT : S_READY;
            r_cnt      <= '0;
            r_inflight <= 2'b00;
            r_held     <= 2'b00;
            r_last     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_cnt <= r_cnt + AW'(1);
            end
            if (|w_grant) begin
                r_last <= w_gsel;
            end
            r_inflight <= w_grant & ~req_w_i;
            for (int i = 0; i < 2; i++) begin
                if (r_inflight[i] && !resp_yumi_i[i]) begin
                    r_held[i] <= 1'b1;
                end else if (r_held[i] && resp_yumi_i[i]) begin
                    r_held[i] <= 1'b0;
                end
            end
        end
    end

    // SRAM output is only valid for one cycle, so an unaccepted response is parked here.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (r_inflight[i] && !resp_yumi_i[i]) begin
                r_hold[i] <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_bsg_manycore_block_mem_arb.sv
// Directed bench for bsg_manycore_block_mem_arb with a behavioural 1-cycle SRAM model.
module tb_bsg_manycore_block_mem_arb;

    localparam int DW = 32;
    localparam int N  = 16;
    localparam int AW = 4;
    localparam int MW = 4;

    logic            clk;
    logic            reset_i;
    logic [1:0]      req_v_i;
    logic [1:0]      req_w_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_data_i;
    logic [2*MW-1:0] req_mask_i;
    logic [1:0]      req_ready_o;
    logic [1:0]      resp_v_o;
    logic [2*DW-1:0] resp_data_o;
    logic [1:0]      resp_yumi_i;
    logic            init_done_o;
    logic            mem_v_o;
    logic            mem_w_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [MW-1:0]   mem_mask_o;
    logic [DW-1:0]   mem_data_i;

    logic [DW-1:0]   sram [N];

    int n_tests;
    int n_fail;

    bsg_manycore_block_mem_arb #(
        .data_width_p        (DW),
        .mem_size_in_words_p (N),
        .zero_init_p         (1)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_v_i     (req_v_i),
        .req_w_i     (req_w_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_mask_i  (req_mask_i),
        .req_ready_o (req_ready_o),
        .resp_v_o    (resp_v_o),
        .resp_data_o (resp_data_o),
        .resp_yumi_i (resp_yumi_i),
        .init_done_o (init_done_o),
        .mem_v_o     (mem_v_o),
        .mem_w_o     (mem_w_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_mask_o  (mem_mask_o),
        .mem_data_i  (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < MW; b++) begin
                    if (mem_mask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
                end
            end else begin
                mem_data_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_v_i[p]             = v;
        req_w_i[p]             = w;
        req_addr_i[p*AW +: AW] = a;
        req_data_i[p*DW +: DW] = d;
        req_mask_i[p*MW +: MW] = m;
    endtask

    logic [1:0] exp_rdy [4];
    logic [1:0] exp_rsp [4];
    int nonzero;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_i = 1'b1;
        req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
        resp_yumi_i = '0;
        mem_data_i  = '0;
        for (int i = 0; i < N; i++) sram[i] = $urandom | 32'h1;
        tick(); tick(); #1;
        chk("rst_mem_v", 64'(mem_v_o), 64'd0);
        chk("rst_done", 64'(init_done_o), 64'd0);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_resp_v", 64'(resp_v_o), 64'd0);

        // Zero-fill sweep with both ports requesting: no ready may leak out.
        @(posedge clk); #1;
        reset_i = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'd1, '0, '0);
        set_req(1, 1'b1, 1'b0, 4'd2, '0, '0);
        for (int k = 0; k < N; k++) begin
            #1;
            chk("init_v", 64'({mem_v_o, mem_w_o}), 64'h3);
            chk("init_addr", 64'(mem_addr_o), 64'(k));
            chk("init_dm", 64'({mem_data_o, mem_mask_o}), 64'hf);
            chk("init_rdy_done", 64'({req_ready_o, init_done_o}), 64'd0);
            tick();
        end
        req_v_i = 2'b00; #1;
        chk("done_rise", 64'(init_done_o), 64'd1);
        nonzero = 0;
        for (int i = 0; i < N; i++) if (sram[i] != 0) nonzero++;
        chk("zero_fill", 64'(nonzero), 64'd0);

        // Seed addr 5 through port 1.
        set_req(1, 1'b1, 1'b1, 4'd5, 32'hA5A5A5A5, 4'hf); #1;
        chk("seed_rdy", 64'(req_ready_o), 64'h2);
        chk("seed_mem", 64'({mem_w_o, mem_addr_o, mem_data_o}), {27'd0, 1'b1, 4'd5, 32'hA5A5A5A5});
        tick();

        // Both ports reading every cycle, yumi high: last winner was port 1.
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rsp = '{2'b00, 2'b01, 2'b10, 2'b01};
        set_req(0, 1'b1, 1'b0, 4'd5, '0, '0);
        set_req(1, 1'b1, 1'b0, 4'd7, '0, '0);
        resp_yumi_i = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_rdy", 64'(req_ready_o), 64'(exp_rdy[c]));
            chk("rr_rsp_v", 64'(resp_v_o), 64'(exp_rsp[c]));
            if (c == 1 || c == 3) chk("rr_data0", 64'(resp_data_o[31:0]), 64'hA5A5A5A5);
            if (c == 2) chk("rr_data1", 64'(resp_data_o[63:32]), 64'd0);
            tick();
        end
        req_v_i = 2'b00; #1;
        chk("rr_drain", 64'(resp_v_o), 64'h2);
        tick(); #1;
        chk("rr_idle", 64'(resp_v_o), 64'h0);

        // Port 0 stalls its consumer; port 1 writes keep flowing.
        resp_yumi_i = 2'b00;
        set_req(0, 1'b1, 1'b0, 4'd5, '0, '0); #1;
        chk("bp_grant0", 64'(req_ready_o), 64'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b1, 4'd9, 32'h11110000 + k, 4'hf); #1;
            chk("bp_rdy", 64'(req_ready_o), 64'h2);
            chk("bp_rsp_v", 64'(resp_v_o), 64'h1);
            chk("bp_hold", 64'(resp_data_o[31:0]), 64'hA5A5A5A5);
            tick();
        end
        req_v_i[1] = 1'b0;
        resp_yumi_i = 2'b01; #1;
        chk("bp_release_rdy", 64'(req_ready_o), 64'h1);
        tick();
        req_v_i = 2'b00; #1;
        chk("bp_second", 64'({resp_v_o, resp_data_o[31:0]}), {30'd0, 2'b01, 32'hA5A5A5A5});
        tick();
        resp_yumi_i = 2'b00; #1;
        chk("bp_idle", 64'(resp_v_o), 64'h0);
        chk("bp_wr9", 64'(sram[9]), 64'h11110003);

        // Masked write then read-after-write.
        set_req(1, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'b0011); #1;
        chk("mask_rdy", 64'(req_ready_o), 64'h2);
        chk("mask_mem", 64'({mem_mask_o, mem_data_o}), {28'd0, 4'b0011, 32'hDEADBEEF});
        tick();
        set_req(1, 1'b1, 1'b0, 4'd3, '0, '0);
        resp_yumi_i = 2'b10; #1;
        chk("raw_rdy", 64'({req_ready_o, mem_w_o}), {61'd0, 2'b10, 1'b0});
        tick();
        req_v_i = 2'b00; #1;
        chk("raw_data", 64'({resp_v_o, resp_data_o[63:32]}), {30'd0, 2'b10, 32'h0000BEEF});
        tick();

        // Port 1 response held, then reset.
        resp_yumi_i = 2'b00;
        set_req(1, 1'b1, 1'b0, 4'd3, '0, '0); #1;
        chk("held_rdy", 64'(req_ready_o), 64'h2);
        tick();
        req_v_i = 2'b00;
        tick(); #1;
        chk("held_v", 64'({resp_v_o, resp_data_o[63:32]}), {30'd0, 2'b10, 32'h0000BEEF});
        reset_i = 1'b1; #1;
        chk("held_rst_out", 64'({resp_v_o, mem_v_o, init_done_o}), 64'd0);
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("sw1_addr", 64'(mem_addr_o), 64'(k));
            chk("sw1_rsp", 64'(resp_v_o), 64'd0);
            tick();
        end

        // Reset at INIT cycle 7: sweep restarts from 0.
        reset_i = 1'b1; #1;
        chk("sw_rst_out", 64'({mem_v_o, init_done_o}), 64'd0);
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            #1;
            chk("sw2_addr", 64'({mem_v_o, mem_addr_o}), 64'(16 + k));
            chk("sw2_done_rsp", 64'({init_done_o, resp_v_o}), 64'd0);
            tick();
        end
        #1;
        chk("sw2_done", 64'(init_done_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("no_stale", 64'(resp_v_o), 64'd0);
            tick(); #1;
        end
        set_req(1, 1'b1, 1'b0, 4'd3, '0, '0);
        resp_yumi_i = 2'b10; #1;
        chk("post_rdy", 64'(req_ready_o), 64'h2);
        tick();
        req_v_i = 2'b00; #1;
        chk("post_zero", 64'({resp_v_o, resp_data_o[63:32]}), {30'd0, 2'b10, 32'h0});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
